core_load_store_unit: RTL and testbench

- Sits between the single-cycle core's data-memory request path and a word-organised data RAM.
- Accepts one byte/half/word load or store per handshake and checks alignment.
- Sub-word stores are done as read-modify-write; the RAM has no byte enables.
- Load data is returned sign- or zero-extended on a one-cycle response pulse.

---
 rtl/core_load_store_unit_pkg.sv | 34 +++
 rtl/core_lsu_lane_align.sv | 44 ++++
 rtl/core_load_store_unit.sv | 139 +++++++++++++
 tb/tb_core_load_store_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, data width and FSM states.
package core_load_store_unit_pkg;

  localparam int LSU_DATA_WIDTH = 32;

  localparam logic [1:0] LSU_SIZE_B   = 2'b00;
  localparam logic [1:0] LSU_SIZE_H   = 2'b01;
  localparam logic [1:0] LSU_SIZE_W   = 2'b10;
  localparam logic [1:0] LSU_SIZE_ILL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_RDATA    = 3'd2,
    ST_WRITE    = 3'd3,
    ST_RESP     = 3'd4,
    ST_ERR_RESP = 3'd5
  } lsu_state_e;

  // A request is rejected if its size is illegal or its address is not
  // naturally aligned for that size.
  function automatic logic lsu_bad_access(input logic [1:0] size, input logic [1:0] addr);
    logic bad;
    bad = 1'b0;
    case (size)
      LSU_SIZE_H: bad = addr[0];
      LSU_SIZE_W: bad = (addr != 2'b00);
      LSU_SIZE_ILL: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/core_lsu_lane_align.sv
// Little-endian lane logic: extracts/extends load data from a RAM word and
// merges sub-word store data into a RAM word. Purely combinational.
module core_lsu_lane_align
  import core_load_store_unit_pkg::*;
(
  input  logic [LSU_DATA_WIDTH-1:0] word,
  input  logic [1:0]                addr,
  input  logic [1:0]                size,
  input  logic                      is_unsigned,
  input  logic [LSU_DATA_WIDTH-1:0] wdata,
  output logic [LSU_DATA_WIDTH-1:0] load_data,
  output logic [LSU_DATA_WIDTH-1:0] store_word
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic        fill;

  // Select the addressed lane, extend it for loads, and splice it for stores.
  always_comb begin
    load_data  = word;
    store_word = word;
    byte_val   = word[{addr, 3'b000} +: 8];
    half_val   = word[{addr[1], 4'b0000} +: 16];
    fill       = 1'b0;
    case (size)
      LSU_SIZE_B: begin
        fill       = ~is_unsigned & byte_val[7];
        load_data  = {{24{fill}}, byte_val};
        store_word[{addr, 3'b000} +: 8] = wdata[7:0];
      end
      LSU_SIZE_H: begin
        fill       = ~is_unsigned & half_val[15];
        load_data  = {{16{fill}}, half_val};
        store_word[{addr[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data  = word;
        store_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/core_load_store_unit.sv
// Load/store unit between the core's data request port and a word-organised
// RAM without byte enables. Sub-word stores use read-modify-write.
//
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both high; ready is high only in IDLE, so request inputs are
// ignored at all other times. Completion is a single-cycle rsp_valid_o pulse
// with rsp_err_o and rsp_rdata_o qualified by it.
module core_load_store_unit
  import core_load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = LSU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  mem_re_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-3:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  lsu_state_e state;
  lsu_state_e state_next;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  we_q;
  logic                  uns_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] wr_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  accept;
  logic                  bad_req;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] store_word;

  assign accept  = req_valid_i && (state == ST_IDLE);
  assign bad_req = lsu_bad_access(req_size_i, req_addr_i[1:0]);

  core_lsu_lane_align u_lane_align (
    .word        (mem_rdata_i),
    .addr        (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  // State register; reset aborts any in-flight access, dropping a pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state and strobe decode; strobes come straight from state so a reset
  // removes them in the same instant.
  always_comb begin
    state_next  = state;
    req_ready_o = 1'b0;
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_err_o   = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (bad_req)                                state_next = ST_ERR_RESP;
          else if (req_we_i && req_size_i == LSU_SIZE_W) state_next = ST_WRITE;
          else                                        state_next = ST_READ;
        end
      end
      ST_READ: begin
        mem_re_o   = 1'b1;
        state_next = ST_RDATA;
      end
      ST_RDATA: begin
        state_next = we_q ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        mem_we_o   = 1'b1;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        state_next  = ST_IDLE;
      end
      ST_ERR_RESP: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = 1'b1;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request latches, write word and response data. The write word starts as
  // the store data so word stores can go straight to WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      wr_q    <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      addr_q  <= req_addr_i;
      size_q  <= req_size_i;
      we_q    <= req_we_i;
      uns_q   <= req_unsigned_i;
      wdata_q <= req_wdata_i;
      wr_q    <= req_wdata_i;
      rdata_q <= '0;
    end else if (state == ST_RDATA) begin
      if (we_q) wr_q    <= store_word;
      else      rdata_q <= load_data;
    end
  end

  assign mem_addr_o  = addr_q[ADDR_WIDTH-1:2];
  assign mem_wdata_o = wr_q;
  assign rsp_rdata_o = rdata_q;

endmodule

// File: tb/tb_core_load_store_unit.sv
// Bench for core_load_store_unit: RAM model, directed cases and randomized
// requests checked against a word-array reference of memory.
module tb_core_load_store_unit;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_we_i = 1'b0;
  logic [1:0]    req_size_i = 2'b00;
  logic          req_unsigned_i = 1'b0;
  logic [AW-1:0] req_addr_i = '0;
  logic [31:0]   req_wdata_i = '0;
  logic          rsp_valid_o;
  logic [31:0]   rsp_rdata_o;
  logic          rsp_err_o;
  logic          mem_re_o;
  logic          mem_we_o;
  logic [AW-3:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [31:0]   mem_rdata_i = '0;

  core_load_store_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .mem_re_o       (mem_re_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- RAM model (one-cycle read latency) ----------------
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
    if (mem_re_o) mem_rdata_i <= ram[mem_addr_o];
  end

  // ---------------- strobe monitor ----------------
  int          re_cnt, we_cnt, both_cnt;
  logic [7:0]  last_waddr;
  logic [31:0] last_wdata;
  always @(negedge clk) begin
    if (mem_re_o) re_cnt++;
    if (mem_we_o) begin
      we_cnt++;
      last_waddr = mem_addr_o;
      last_wdata = mem_wdata_o;
    end
    if (mem_re_o && mem_we_o) both_cnt++;
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic ref_err(input logic [1:0] size, input logic [AW-1:0] addr);
    int a;
    a = int'(addr);
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1) return (a % 2) != 0;
    if (size == 2'd2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [AW-1:0] addr,
                                           input logic [1:0] size, input logic uns);
    logic [31:0] v;
    int sh;
    v = word;
    if (size == 2'd0) begin
      sh = 8 * (int'(addr) % 4);
      v = (word >> sh) & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      sh = 16 * ((int'(addr) / 2) % 2);
      v = (word >> sh) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [AW-1:0] addr,
                                            input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] base;
    logic [31:0] mask;
    int sh;
    if (size == 2'd2) return wdata;
    base = (size == 2'd0) ? 32'hFF : 32'hFFFF;
    sh   = (size == 2'd0) ? 8 * (int'(addr) % 4) : 16 * ((int'(addr) / 2) % 2);
    mask = base << sh;
    return (word & ~mask) | ((wdata & base) << sh);
  endfunction

  // ---------------- driver ----------------
  // One request through the idle handshake; checks latency, response, strobes
  // and the written word, and updates the reference memory.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [AW-1:0] addr, input logic [31:0] wdata);
    logic        e;
    int          exp_lat, lat, widx;
    logic [31:0] exp_rd, exp_word;
    e    = ref_err(size, addr);
    widx = int'(addr) / 4;
    if (e)                   exp_lat = 1;
    else if (!we)            exp_lat = 3;
    else if (size == 2'd2)   exp_lat = 2;
    else                     exp_lat = 4;
    exp_rd   = (e || we) ? 32'h0 : ref_load(ref_mem[widx], addr, size, uns);
    exp_word = ref_store(ref_mem[widx], addr, size, wdata);

    @(negedge clk);
    check("idle_ready", {31'b0, req_ready_o}, 32'd1);
    re_cnt = 0; we_cnt = 0; both_cnt = 0;
    req_valid_i = 1'b1; req_we_i = we; req_size_i = size;
    req_unsigned_i = uns; req_addr_i = addr; req_wdata_i = wdata;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    req_addr_i = AW'($urandom); req_wdata_i = $urandom; req_size_i = 2'($urandom);
    check("busy_ready", {31'b0, req_ready_o}, 32'd0);
    lat = 1;
    while (!rsp_valid_o && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("rsp_err", {31'b0, rsp_err_o}, {31'b0, e});
    check("rsp_rdata", rsp_rdata_o, exp_rd);
    check("re_count", re_cnt, (!e && (!we || size != 2'd2)) ? 1 : 0);
    check("we_count", we_cnt, (!e && we) ? 1 : 0);
    check("re_we_overlap", both_cnt, 0);
    if (!e && we) begin
      check("waddr", {24'b0, last_waddr}, widx);
      check("wdata", last_wdata, exp_word);
      ref_mem[widx] = exp_word;
    end
    @(posedge clk); #1;
    check("rsp_pulse_once", {31'b0, rsp_valid_o}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    re_cnt = 0; we_cnt = 0; both_cnt = 0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, req_ready_o}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err_o}, 32'd0);
    check("rst_mem_re", {31'b0, mem_re_o}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we_o}, 32'd0);
    check("rst_rdata", rsp_rdata_o, 32'd0);
    check("rst_mem_addr", {24'b0, mem_addr_o}, 32'd0);
    check("rst_mem_wdata", mem_wdata_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // word store then loads from the same word
    do_req(1'b1, 2'd2, 1'b0, 10'h010, 32'hDEAD_BEEF);
    check("sw_ram", ram[4], 32'hDEAD_BEEF);
    do_req(1'b1, 2'd2, 1'b0, 10'h010, 32'h8000_7F01);
    do_req(1'b0, 2'd0, 1'b0, 10'h013, 32'h0);
    do_req(1'b0, 2'd0, 1'b1, 10'h013, 32'h0);
    do_req(1'b0, 2'd1, 1'b0, 10'h012, 32'h0);
    do_req(1'b0, 2'd0, 1'b0, 10'h010, 32'h0);
    check("lb_const", ref_load(32'h8000_7F01, 10'h013, 2'd0, 1'b0), 32'hFFFF_FF80);

    // sub-word read-modify-write
    do_req(1'b1, 2'd2, 1'b0, 10'h010, 32'h1122_3344);
    do_req(1'b1, 2'd0, 1'b0, 10'h011, 32'h0000_00AA);
    check("sb_ram", ram[4], 32'h1122_AA44);
    do_req(1'b1, 2'd2, 1'b0, 10'h010, 32'h1122_3344);
    do_req(1'b1, 2'd1, 1'b0, 10'h012, 32'h0000_BEEF);
    check("sh_ram", ram[4], 32'hBEEF_3344);

    // errors: misaligned word and illegal size
    do_req(1'b0, 2'd2, 1'b0, 10'h012, 32'h0);
    do_req(1'b1, 2'd3, 1'b0, 10'h010, 32'h1234_5678);
    do_req(1'b1, 2'd1, 1'b0, 10'h015, 32'h1234_5678);
    check("err_ram", ram[4], 32'hBEEF_3344);

    // valid held over three loads
    begin
      logic [AW-1:0] ha [3];
      logic [1:0]    hs [3];
      int got, idx;
      ha[0] = 10'h013; ha[1] = 10'h012; ha[2] = 10'h010;
      hs[0] = 2'd0;    hs[1] = 2'd1;    hs[2] = 2'd0;
      for (int i = 0; i < 3; i++) exp_q.push_back(ref_load(ref_mem[4], ha[i], hs[i], 1'b0));
      got = 0; idx = 0;
      @(negedge clk);
      req_valid_i = 1'b1; req_we_i = 1'b0; req_unsigned_i = 1'b0;
      req_addr_i = ha[0]; req_size_i = hs[0];
      for (int c = 0; c < 40 && got < 3; c++) begin
        @(posedge clk); #1;
        if (c == 0) check("hold_busy", {31'b0, req_ready_o}, 32'd0);
        if (rsp_valid_o) begin
          check("hold_rsp_ready", {31'b0, req_ready_o}, 32'd0);
          if (exp_q.size() > 0) check("hold_data", rsp_rdata_o, exp_q.pop_front());
          got++; idx++;
          if (idx < 3) begin
            req_addr_i = ha[idx]; req_size_i = hs[idx];
          end else begin
            req_valid_i = 1'b0;
          end
        end
      end
      req_valid_i = 1'b0;
      check("hold_count", got, 3);
      check("hold_queue_empty", exp_q.size(), 0);
      @(posedge clk); #1;
    end

    // randomized requests
    for (int n = 0; n < 80; n++) begin
      do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
             AW'($urandom_range(0, 63)), $urandom);
    end

    // reset during RDATA of a half store: the write must never happen
    do_req(1'b1, 2'd2, 1'b0, 10'h010, 32'hCAFE_F00D);
    @(negedge clk);
    re_cnt = 0; we_cnt = 0;
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'd1;
    req_addr_i = 10'h010; req_wdata_i = 32'h0000_1234;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("abort_we_count", we_cnt, 0);
    check("abort_ram", ram[4], 32'hCAFE_F00D);
    check("abort_ready", {31'b0, req_ready_o}, 32'd1);
    check("abort_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    check("abort_mem_re", {31'b0, mem_re_o}, 32'd0);
    check("abort_mem_we", {31'b0, mem_we_o}, 32'd0);
    check("abort_rdata", rsp_rdata_o, 32'd0);
    check("abort_mem_addr", {24'b0, mem_addr_o}, 32'd0);
    check("abort_mem_wdata", mem_wdata_o, 32'd0);

    // unit still works after the abort
    do_req(1'b0, 2'd1, 1'b1, 10'h012, 32'h0);

    // whole-memory comparison against the reference
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) bad++;
      check("ram_contents", bad, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
